// File: rtl/dotp_accumulator.sv
// Reduction stage of the SIMD datapath: sums all lanes of each DOTP beat into a
// wide accumulator and hands out one signed result per STORE_RESULT.
module dotp_accumulator #(
   parameter int NUM_LANES    = 8,
   parameter int ACC_W        = 48,
   parameter int OPCODE_WIDTH = 4
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [OPCODE_WIDTH-1:0] in_opcode,
   input  logic [NUM_LANES*32-1:0] in_data,
   output logic                    res_valid,
   input  logic                    res_ready,
   output logic [ACC_W-1:0]        res_data,
   output logic                    res_ovf,
   output logic                    done,
   output logic [1:0]              dbg_state_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC  = 2'd1,
      ST_HOLD = 2'd2
   } state_e;

   localparam logic [OPCODE_WIDTH-1:0] OP_DOTP  = OPCODE_WIDTH'(4);
   localparam logic [OPCODE_WIDTH-1:0] OP_STORE = OPCODE_WIDTH'(7);
   localparam logic [OPCODE_WIDTH-1:0] OP_STOP  = OPCODE_WIDTH'(8);

   logic                    stall;
   logic                    accept;
   logic [ACC_W-1:0]        lane_sum;
   logic [ACC_W-1:0]        dotp_sum;
   logic                    s1_valid_q, s1_valid_d;
   logic [OPCODE_WIDTH-1:0] s1_op_q, s1_op_d;
   logic [ACC_W-1:0]        s1_sum_q, s1_sum_d;
   logic [ACC_W-1:0]        acc_q, acc_d;
   logic                    ovf_q, ovf_d;
   logic                    res_valid_q, res_valid_d;
   logic [ACC_W-1:0]        res_data_q, res_data_d;
   logic                    res_ovf_q, res_ovf_d;
   logic                    done_q, done_d;
   state_e                  state;

   // A held result that the consumer refuses freezes both stages.
   assign stall    = res_valid_q && !res_ready;
   assign in_ready = !stall;
   assign accept   = in_valid && in_ready;

   always_comb begin
      lane_sum = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         lane_sum = lane_sum + {{(ACC_W-32){in_data[32*i+31]}}, in_data[32*i +: 32]};
      end
   end

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_op_d    = s1_op_q;
      s1_sum_d   = s1_sum_q;
      if (!stall) begin
         s1_valid_d = accept;
         if (accept) begin
            s1_op_d  = in_opcode;
            s1_sum_d = lane_sum;
         end
      end
   end

   always_comb begin
      acc_d       = acc_q;
      ovf_d       = ovf_q;
      res_data_d  = res_data_q;
      res_ovf_d   = res_ovf_q;
      res_valid_d = res_valid_q && !res_ready;
      done_d      = 1'b0;
      dotp_sum    = acc_q + s1_sum_q;
      if (s1_valid_q && !stall) begin
         case (s1_op_q)
            OP_DOTP: begin
               acc_d = dotp_sum;
               // Same-sign operands producing an opposite-sign sum wrapped.
               if ((acc_q[ACC_W-1] == s1_sum_q[ACC_W-1]) &&
                   (dotp_sum[ACC_W-1] != acc_q[ACC_W-1])) begin
                  ovf_d = 1'b1;
               end
            end
            OP_STORE: begin
               res_data_d  = acc_q;
               res_ovf_d   = ovf_q;
               res_valid_d = 1'b1;
               acc_d       = '0;
               ovf_d       = 1'b0;
            end
            OP_STOP: begin
               acc_d  = '0;
               ovf_d  = 1'b0;
               done_d = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         s1_valid_q  <= 1'b0;
         s1_op_q     <= '0;
         s1_sum_q    <= '0;
         acc_q       <= '0;
         ovf_q       <= 1'b0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         res_ovf_q   <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_op_q     <= s1_op_d;
         s1_sum_q    <= s1_sum_d;
         acc_q       <= acc_d;
         ovf_q       <= ovf_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
         res_ovf_q   <= res_ovf_d;
         done_q      <= done_d;
      end
   end

   // Debug state is a pure function of the registered datapath state.
   always_comb begin
      state = ST_IDLE;
      if (res_valid_q) begin
         state = ST_HOLD;
      end else if ((acc_q != '0) || ovf_q) begin
         state = ST_ACC;
      end
   end

   assign res_valid   = res_valid_q;
   assign res_data    = res_data_q;
   assign res_ovf     = res_ovf_q;
   assign done        = done_q;
   assign dbg_state_o = state;

endmodule

// File: tb/tb_dotp_accumulator.sv
// Bench for dotp_accumulator: an 8-lane/48-bit and a 4-lane/34-bit instance share
// stimulus; a transaction-level model predicts every handed-over result.
module tb_dotp_accumulator;

   logic         clk = 1'b0;
   logic         rstn;
   logic         in_valid;
   logic [3:0]   in_opcode;
   logic [255:0] in_data;
   logic         res_ready;

   logic         in_ready_a, res_valid_a, res_ovf_a, done_a;
   logic [47:0]  res_data_a;
   logic [1:0]   dbg_a;
   logic         in_ready_b, res_valid_b, res_ovf_b, done_b;
   logic [33:0]  res_data_b;
   logic [1:0]   dbg_b;

   int           n_tests = 0;
   int           n_fail  = 0;
   int           last_waits;
   int           lanes[8];
   longint       acc_a, acc_b;
   bit           ovf_a, ovf_b;
   logic [48:0]  exp_q[$];
   logic [34:0]  exp_b_q[$];

   always #5 clk = ~clk;

   dotp_accumulator #(.NUM_LANES(8), .ACC_W(48), .OPCODE_WIDTH(4)) dut_a (
      .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready_a),
      .in_opcode(in_opcode), .in_data(in_data), .res_valid(res_valid_a),
      .res_ready(res_ready), .res_data(res_data_a), .res_ovf(res_ovf_a),
      .done(done_a), .dbg_state_o(dbg_a)
   );

   dotp_accumulator #(.NUM_LANES(4), .ACC_W(34), .OPCODE_WIDTH(4)) dut_b (
      .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready_b),
      .in_opcode(in_opcode), .in_data(in_data[127:0]), .res_valid(res_valid_b),
      .res_ready(res_ready), .res_data(res_data_b), .res_ovf(res_ovf_b),
      .done(done_b), .dbg_state_o(dbg_b)
   );

   // Result monitor: every handshake must match the oldest predicted result.
   always @(negedge clk) begin
      if (rstn && res_valid_a && res_ready) begin
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL result_a unexpected: got %h, none expected", {res_ovf_a, res_data_a});
         end else begin
            logic [48:0] e;
            e = exp_q.pop_front();
            if ({res_ovf_a, res_data_a} !== e) begin
               n_fail++;
               $display("FAIL result_a: got ovf=%b data=%h, expected ovf=%b data=%h",
                        res_ovf_a, res_data_a, e[48], e[47:0]);
            end
         end
         n_tests++;
         if (!res_valid_b || exp_b_q.size() == 0) begin
            n_fail++;
            $display("FAIL result_b missing: valid=%b queued=%0d", res_valid_b, exp_b_q.size());
         end else begin
            logic [34:0] eb;
            eb = exp_b_q.pop_front();
            if ({res_ovf_b, res_data_b} !== eb) begin
               n_fail++;
               $display("FAIL result_b: got ovf=%b data=%h, expected ovf=%b data=%h",
                        res_ovf_b, res_data_b, eb[34], eb[33:0]);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic model_add(input longint ls, input int w, inout longint acc, inout bit ovf);
      longint mx, mn, t;
      mx = (longint'(1) <<< (w - 1)) - 1;
      mn = -mx - 1;
      t  = acc + ls;
      if (t > mx || t < mn) ovf = 1'b1;
      if (t > mx) t = t - (longint'(1) <<< w);
      else if (t < mn) t = t + (longint'(1) <<< w);
      acc = t;
   endtask

   task automatic model_clear();
      acc_a = 0; acc_b = 0; ovf_a = 0; ovf_b = 0;
   endtask

   task automatic model_accept(input logic [3:0] op);
      longint ls8, ls4;
      ls8 = 0; ls4 = 0;
      for (int i = 0; i < 8; i++) begin
         ls8 += longint'(lanes[i]);
         if (i < 4) ls4 += longint'(lanes[i]);
      end
      case (op)
         4'd4: begin
            model_add(ls8, 48, acc_a, ovf_a);
            model_add(ls4, 34, acc_b, ovf_b);
         end
         4'd7: begin
            exp_q.push_back({ovf_a, acc_a[47:0]});
            exp_b_q.push_back({ovf_b, acc_b[33:0]});
            model_clear();
         end
         4'd8: model_clear();
         default: ;
      endcase
   endtask

   task automatic rand_lanes(input int mode);
      for (int i = 0; i < 8; i++) begin
         case (mode)
            1: lanes[i] = 32'h7FFF_FFFF;
            2: lanes[i] = 32'h8000_0000;
            3: lanes[i] = $urandom_range(0, 200) - 100;
            default: lanes[i] = $urandom;
         endcase
      end
   endtask

   // Presents one beat, waits (bounded) for in_ready, and records it in the model.
   task automatic send_beat(input logic [3:0] op, input bit rnd_ready);
      in_opcode = op;
      for (int i = 0; i < 8; i++) in_data[32*i +: 32] = lanes[i];
      in_valid   = 1'b1;
      last_waits = 0;
      forever begin
         #1;
         if (in_ready_a) break;
         if (last_waits >= 200) begin
            n_tests++; n_fail++;
            $display("FAIL send_beat timeout: in_ready=%b op=%0d", in_ready_a, op);
            in_valid = 1'b0;
            return;
         end
         last_waits++;
         step();
         if (rnd_ready) res_ready = ($urandom_range(0, 3) != 0);
      end
      step();
      in_valid = 1'b0;
      model_accept(op);
   endtask

   task automatic drain();
      res_ready = 1'b1;
      for (int i = 0; i < 30 && (exp_q.size() != 0 || res_valid_a); i++) step();
      n_tests++;
      if (exp_q.size() != 0 || exp_b_q.size() != 0 || res_valid_a) begin
         n_fail++;
         $display("FAIL drain: pending_a=%0d pending_b=%0d res_valid=%b, expected 0 0 0",
                  exp_q.size(), exp_b_q.size(), res_valid_a);
      end
   endtask

   task automatic test_reset();
      rstn = 1'b0; in_valid = 1'b1; in_opcode = 4'd7; res_ready = 1'b0;
      in_data = '1;
      for (int c = 0; c < 3; c++) begin
         step();
         n_tests++;
         if ({res_valid_a, res_data_a, res_ovf_a, done_a, in_ready_a, dbg_a} !== {1'b0, 48'd0, 1'b0, 1'b0, 1'b1, 2'd0} ||
             {res_valid_b, res_data_b, res_ovf_b, done_b, in_ready_b, dbg_b} !== {1'b0, 34'd0, 1'b0, 1'b0, 1'b1, 2'd0}) begin
            n_fail++;
            $display("FAIL reset_outputs cycle %0d: a v=%b d=%h o=%b done=%b rdy=%b st=%0d, b v=%b d=%h, expected zeros rdy=1",
                     c, res_valid_a, res_data_a, res_ovf_a, done_a, in_ready_a, dbg_a, res_valid_b, res_data_b);
         end
      end
      rstn = 1'b1; in_valid = 1'b0;
      model_clear();
      step();
   endtask

   task automatic test_basic();
      res_ready = 1'b1;
      for (int i = 0; i < 8; i++) lanes[i] = 3;
      send_beat(4'd4, 0);
      for (int i = 0; i < 8; i++) lanes[i] = i;
      send_beat(4'd4, 0);
      send_beat(4'd7, 0);
      n_tests++;
      if (res_valid_a !== 1'b0) begin
         n_fail++; $display("FAIL basic_early: res_valid=%b expected 0", res_valid_a);
      end
      step();
      n_tests++;
      if (res_valid_a !== 1'b1 || res_data_a !== 48'd52 || res_ovf_a !== 1'b0 || res_data_b !== 34'd18) begin
         n_fail++;
         $display("FAIL basic_result: v=%b a=%0d ovf=%b b=%0d, expected v=1 a=52 ovf=0 b=18",
                  res_valid_a, res_data_a, res_ovf_a, res_data_b);
      end
      step();
      n_tests++;
      if (res_valid_a !== 1'b0) begin
         n_fail++; $display("FAIL basic_one_cycle: res_valid=%b expected 0", res_valid_a);
      end
   endtask

   task automatic test_signed();
      res_ready = 1'b1;
      for (int i = 0; i < 8; i++) lanes[i] = -1;
      send_beat(4'd4, 0);
      send_beat(4'd7, 0);
      step();
      n_tests++;
      if (res_data_a !== 48'hFFFF_FFFF_FFF8 || res_data_b !== 34'h3_FFFF_FFFC || res_ovf_a !== 1'b0) begin
         n_fail++;
         $display("FAIL signed: a=%h b=%h ovf=%b, expected a=fffffffffff8 b=3fffffffc ovf=0",
                  res_data_a, res_data_b, res_ovf_a);
      end
      drain();
   endtask

   task automatic test_backpressure();
      logic [47:0] held;
      res_ready = 1'b0;
      rand_lanes(0); send_beat(4'd4, 0);
      send_beat(4'd7, 0);
      held = exp_q[0][47:0];
      rand_lanes(0); send_beat(4'd4, 0);
      rand_lanes(0);
      in_opcode = 4'd4;
      for (int i = 0; i < 8; i++) in_data[32*i +: 32] = lanes[i];
      in_valid = 1'b1;
      for (int c = 0; c < 4; c++) begin
         step();
         n_tests++;
         if (in_ready_a !== 1'b0 || in_ready_b !== 1'b0 || res_valid_a !== 1'b1 ||
             res_data_a !== held || dbg_a !== 2'd2) begin
            n_fail++;
            $display("FAIL backpressure_hold c%0d: rdy=%b/%b v=%b d=%h st=%0d, expected 0/0 1 %h 2",
                     c, in_ready_a, in_ready_b, res_valid_a, res_data_a, dbg_a, held);
         end
      end
      res_ready = 1'b1;
      send_beat(4'd4, 0);
      send_beat(4'd7, 0);
      drain();
   endtask

   task automatic test_back_to_back();
      int total_waits;
      total_waits = 0;
      res_ready = 1'b1;
      rand_lanes(0); send_beat(4'd4, 0); total_waits += last_waits;
      send_beat(4'd7, 0); total_waits += last_waits;
      rand_lanes(3); send_beat(4'd4, 0); total_waits += last_waits;
      send_beat(4'd7, 0); total_waits += last_waits;
      send_beat(4'd7, 0); total_waits += last_waits;
      n_tests++;
      if (total_waits != 0) begin
         n_fail++; $display("FAIL back_to_back_bubbles: waits=%0d expected 0", total_waits);
      end
      drain();
   endtask

   task automatic test_overflow();
      res_ready = 1'b1;
      for (int m = 1; m <= 2; m++) begin
         rand_lanes(m);
         send_beat(4'd4, 0);
         send_beat(4'd4, 0);
         send_beat(4'd7, 0);
         send_beat(4'd7, 0);
         n_tests++;
         if (res_valid_b !== 1'b1 || res_ovf_b !== 1'b1 || res_ovf_a !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_set mode%0d: v=%b ovf_b=%b ovf_a=%b, expected 1 1 0",
                     m, res_valid_b, res_ovf_b, res_ovf_a);
         end
         step();
         n_tests++;
         if (res_valid_b !== 1'b1 || res_ovf_b !== 1'b0 || res_data_b !== 34'd0) begin
            n_fail++;
            $display("FAIL overflow_cleared mode%0d: v=%b ovf_b=%b data_b=%h, expected 1 0 0",
                     m, res_valid_b, res_ovf_b, res_data_b);
         end
         drain();
      end
   endtask

   task automatic test_mixed();
      logic [3:0] ops[11];
      ops = '{4'd4, 4'd1, 4'd4, 4'd3, 4'd0, 4'd12, 4'd4, 4'd5, 4'd6, 4'd15, 4'd7};
      res_ready = 1'b1;
      foreach (ops[k]) begin
         rand_lanes(0);
         send_beat(ops[k], 0);
      end
      rand_lanes(0); send_beat(4'd4, 0);
      rand_lanes(0); send_beat(4'd4, 0);
      send_beat(4'd8, 0);
      n_tests++;
      if (done_a !== 1'b0) begin
         n_fail++; $display("FAIL done_early: done=%b expected 0", done_a);
      end
      step();
      n_tests++;
      if (done_a !== 1'b1 || done_b !== 1'b1) begin
         n_fail++; $display("FAIL done_pulse: done=%b/%b expected 1/1", done_a, done_b);
      end
      step();
      n_tests++;
      if (done_a !== 1'b0) begin
         n_fail++; $display("FAIL done_width: done=%b expected 0", done_a);
      end
      send_beat(4'd7, 0);
      drain();
   endtask

   task automatic test_random();
      for (int n = 0; n < 300; n++) begin
         int pick;
         logic [3:0] op;
         pick = $urandom_range(0, 99);
         if (pick < 60) op = 4'd4;
         else if (pick < 72) op = 4'd7;
         else if (pick < 75) op = 4'd8;
         else op = 4'($urandom_range(0, 15));
         rand_lanes($urandom_range(0, 9) < 7 ? 0 : $urandom_range(1, 3));
         res_ready = ($urandom_range(0, 3) != 0);
         send_beat(op, 1);
         if ($urandom_range(0, 4) == 0) step();
      end
      drain();
   endtask

   task automatic test_reset_pending();
      res_ready = 1'b0;
      rand_lanes(0); send_beat(4'd4, 0);
      send_beat(4'd7, 0);
      step();
      n_tests++;
      if (res_valid_a !== 1'b1) begin
         n_fail++; $display("FAIL pending_before_reset: res_valid=%b expected 1", res_valid_a);
      end
      rstn = 1'b0;
      step();
      rstn = 1'b1;
      exp_q.delete(); exp_b_q.delete(); model_clear();
      n_tests++;
      if (res_valid_a !== 1'b0 || res_data_a !== 48'd0 || in_ready_a !== 1'b1) begin
         n_fail++;
         $display("FAIL pending_discarded: v=%b d=%h rdy=%b, expected 0 0 1", res_valid_a, res_data_a, in_ready_a);
      end
      res_ready = 1'b1;
      send_beat(4'd7, 0);
      drain();
   endtask

   initial begin
      in_valid = 1'b0; in_opcode = '0; in_data = '0; res_ready = 1'b0; rstn = 1'b0;
      model_clear();
      test_reset();
      test_basic();
      test_signed();
      test_backpressure();
      test_back_to_back();
      test_overflow();
      test_mixed();
      test_random();
      test_reset_pending();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/dotp_accumulator.md
# dotp_accumulator

Downstream reduction stage of the SIMD datapath. Consumes the per-lane 32-bit results of the lane ALUs, together with the opcode aligned to those results, and sums all lanes of every DOTP beat into a wide accumulator. It emits one scalar dot-product result per STORE_RESULT opcode over a valid/ready handshake. Two-stage pipeline; backpressure from the result consumer freezes the whole block.

## Interface
- NUM_LANES, 8: number of ALU lanes reduced per beat (power of two, 2..16)
- ACC_W, 48: accumulator and result width in bits (>= 32 + log2(NUM_LANES))
- OPCODE_WIDTH, 4: opcode width, shared with the ALU
- clk  in  1  clock, all state on rising edge
- rstn  in  1  reset, synchronous, active-low
- in_valid  in  1  lane data and opcode valid
- in_ready  out  1  block accepts a beat this cycle
- in_opcode  in  OPCODE_WIDTH  opcode aligned with in_data (ALU registered opcode)
- in_data  in  NUM_LANES*32  lane i at bits [32i+31:32i], signed two's complement
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_data  out  ACC_W  signed dot-product result
- res_ovf  out  1  signed overflow occurred during the accumulation of res_data
- done  out  1  one-cycle pulse when STOP leaves stage 2

## Operation
- Opcode encoding: NOOP=0, ADD=1, SUB=2, MUL=3, DOTP=4, STORE_TEMP_S1=5, STORE_TEMP_S2=6, STORE_RESULT=7, STOP=8; values 9..15 are treated as NOOP.
- Beat accepted when in_valid && in_ready. in_ready = !(res_valid && !res_ready) (stall).
- Stage 1: on accept, register opcode and lane_sum = sum of all lanes, each sign-extended to ACC_W. Register s1_valid. On a cycle with no accept and no stall, s1_valid=0.
- Stage 2, acting on the s1 beat when s1_valid and not stalled:
  - DOTP: acc <= acc + lane_sum (mod 2^ACC_W). Set sticky ovf if signed overflow occurs.
  - STORE_RESULT: res_data <= acc, res_ovf <= ovf, res_valid <= 1, acc <= 0, ovf <= 0.
  - STOP: acc <= 0, ovf <= 0, done pulses 1 cycle. Any held result stays valid.
  - All others: no effect on acc, ovf or result.
- res_valid clears on res_valid && res_ready, unless a new STORE_RESULT completes in the same cycle; then res_data/res_ovf load the new values and res_valid stays 1.
- During a stall, stage 1, stage 2, acc and ovf hold.
- FSM (reported for debug, derivable from state):
  - IDLE (acc==0, ovf==0, !res_valid) -> ACC on a DOTP in stage 2.
  - ACC -> HOLD on STORE_RESULT.
  - ACC -> IDLE on STOP.
  - HOLD (res_valid) -> IDLE/ACC on handshake, depending on acc contents.
- Reset (rstn=0 at a rising edge) has priority over everything. Values after reset: acc=0, ovf=0, s1_valid=0, res_valid=0, res_data=0, res_ovf=0, done=0, in_ready=1. A result pending at reset is discarded.

## Timing
- Beat accepted at edge t updates the s1 registers at t. A DOTP beat updates acc at edge t+1.
- STORE_RESULT accepted at edge t: res_valid is high after edge t+1. The result includes every DOTP accepted at or before t-1.
- Back-to-back DOTP beats at 1 per cycle, no bubbles required.
- STORE_RESULT immediately after the last DOTP (next cycle) must include that DOTP.
- Stall is combinational from res_ready to in_ready; no other combinational input-to-output path.
- done is high for exactly the cycle after the edge at which STOP completes stage 2.

## Test plan
- Reset: hold rstn=0 for 3 cycles with in_valid=1 -> all outputs 0, in_ready=1, no done. Release -> behaviour is the same as from cold start.
- Basic dot product, NUM_LANES=8: DOTP beat with all lanes=3, then DOTP beat with lanes 0..7 = 0..7, then STORE_RESULT, res_ready=1 -> res_data=52, res_ovf=0, res_valid high 2 edges after the STORE_RESULT accept, for 1 cycle.
- Signed: lanes = -1 (0xFFFFFFFF) x8, DOTP, STORE_RESULT -> res_data = -8 sign-extended to 48 bits (0xFFFFFFFFFFF8).
- Backpressure: complete a STORE_RESULT with res_ready=0, then send DOTP x2 + STORE_RESULT -> in_ready=0 while the result is held, first result stable. Raise res_ready -> first result handed over, second result equals the sum of the two DOTP beats only (acc was cleared).
- Overflow, ACC_W=34: DOTP with all lanes=0x7FFFFFFF, repeated until the sum exceeds 2^33-1 -> res_ovf=1 on the STORE_RESULT. A following STORE_RESULT with no DOTP -> res_data=0, res_ovf=0.
- Mixed opcodes: interleave ADD, MUL, NOOP, opcode 12 between DOTP beats -> ignored in the sum. STOP mid-accumulation -> done pulses 1 cycle, next STORE_RESULT gives 0.
